kb_search: RTL and testbench

Candidate-key sequencer that sits directly upstream of the AES key-block checker. It enumerates 448-bit key-block candidates by splicing an index counter into a base block, issues one check per candidate, and waits for the checker's done/valid result. It stops on the first valid candidate or when the index range is exhausted, and reports the winning index and key block to the host side.

---
 rtl/kb_search.sv | 107 ++++++++++
 tb/tb_kb_search.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/kb_search.sv
// Candidate-key sequencer: splices an index counter into a base key block,
// issues one checker request per candidate and stops on first valid or range end.
module kb_search #(
  parameter int unsigned CTR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              go,
  input  logic              abort,
  input  logic [447:0]      base_kb,
  input  logic [CTR_W-1:0]  start_idx,
  input  logic [CTR_W-1:0]  end_idx,
  input  logic              aes_done,
  input  logic              aes_valid,
  output logic [447:0]      kb,
  output logic              aes_start,
  output logic              busy,
  output logic              found,
  output logic              exhausted,
  output logic [CTR_W-1:0]  found_idx,
  output logic [447:0]      found_kb,
  output logic [CTR_W-1:0]  tried
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, DRAIN} state_t;

  state_t             state, state_next;
  logic [447:CTR_W]   base_q;
  logic [CTR_W-1:0]   idx;
  logic [CTR_W-1:0]   end_q;
  logic               empty;
  logic               unused_base_lo;

  // The low base bits are always overwritten by the index.
  assign unused_base_lo = ^base_kb[CTR_W-1:0];

  assign kb    = {base_q, idx};
  assign busy  = (state != IDLE);
  assign empty = (start_idx > end_idx);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (go && !abort && !empty) state_next = ISSUE;
      ISSUE: state_next = abort ? DRAIN : WAIT;
      // Abort coinciding with the result strobe finishes the drain in one step.
      WAIT: begin
        if (aes_done)
          state_next = (abort || aes_valid || idx == end_q) ? IDLE : GAP;
        else if (abort)
          state_next = DRAIN;
      end
      GAP:   state_next = abort ? IDLE : ISSUE;
      DRAIN: if (aes_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      aes_start <= 1'b0;
      base_q    <= '0;
      idx       <= '0;
      end_q     <= '0;
      found     <= 1'b0;
      exhausted <= 1'b0;
      found_idx <= '0;
      found_kb  <= '0;
      tried     <= '0;
    end else if (!stall) begin
      state     <= state_next;
      aes_start <= (state_next == ISSUE);
      case (state)
        IDLE: begin
          if (go && !abort) begin
            base_q    <= base_kb[447:CTR_W];
            end_q     <= end_idx;
            idx       <= start_idx;
            found     <= 1'b0;
            exhausted <= empty;
            found_idx <= '0;
            found_kb  <= '0;
            tried     <= '0;
          end
        end
        WAIT: begin
          if (aes_done && !abort) begin
            tried <= tried + 1'b1;
            if (aes_valid) begin
              found     <= 1'b1;
              found_idx <= idx;
              found_kb  <= kb;
            end else if (idx == end_q) begin
              exhausted <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kb_search.sv
// Directed bench for kb_search with a small fixed-latency checker model.
module tb_kb_search;

  localparam int unsigned CW  = 32;
  localparam int unsigned LAT = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           stall = 1'b0;
  logic           go = 1'b0;
  logic           abort = 1'b0;
  logic [447:0]   base_kb = '0;
  logic [CW-1:0]  start_idx = '0;
  logic [CW-1:0]  end_idx = '0;
  logic           aes_done, aes_valid;
  logic [447:0]   kb;
  logic           aes_start, busy, found, exhausted;
  logic [CW-1:0]  found_idx, tried;
  logic [447:0]   found_kb;

  logic           model_done = 1'b0, model_valid = 1'b0;
  logic           inj_done = 1'b0, inj_valid = 1'b0;
  logic           valid_en = 1'b0;
  logic [CW-1:0]  valid_idx = '0;
  logic [CW-1:0]  latched = '0;
  logic [447:0]   kb_prev = '0;
  logic           start_prev = 1'b0, start_mon = 1'b0;
  int unsigned    cnt = 0;
  int unsigned    pulses = 0;
  int unsigned    violations = 0;
  int unsigned    vectors = 0;
  int unsigned    miscompares = 0;

  assign aes_done  = model_done | inj_done;
  assign aes_valid = model_valid | inj_valid;

  kb_search #(.CTR_W(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .go(go), .abort(abort),
    .base_kb(base_kb), .start_idx(start_idx), .end_idx(end_idx),
    .aes_done(aes_done), .aes_valid(aes_valid), .kb(kb),
    .aes_start(aes_start), .busy(busy), .found(found), .exhausted(exhausted),
    .found_idx(found_idx), .found_kb(found_kb), .tried(tried)
  );

  always #5 clk = ~clk;

  // Checker model: sees aes_start at the edge, answers LAT edges later, frozen by stall.
  always @(negedge clk) begin
    if (aes_start && !start_mon) pulses++;
    if (aes_start && aes_done && !stall) violations++;
    start_mon = aes_start;
    if (rst) begin
      cnt = 0; model_done = 1'b0; model_valid = 1'b0; start_prev = 1'b0;
    end else begin
      if (!stall) begin
        model_done = 1'b0; model_valid = 1'b0;
        if (start_prev) begin
          cnt = LAT; latched = kb_prev[CW-1:0];
        end else if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            model_done  = 1'b1;
            model_valid = valid_en && (latched == valid_idx);
          end
        end
      end
      start_prev = aes_start;
      kb_prev    = kb;
    end
  end

  task automatic check(input string tag, input logic [447:0] got, input logic [447:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic launch(input logic [447:0] b, input logic [CW-1:0] s, input logic [CW-1:0] e);
    base_kb = b; start_idx = s; end_idx = e; go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n = 0;
    while (busy && n < 300) begin tick(); n++; end
    if (busy) check(tag, busy, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_found"}, found, 1'b0);
    check({tag, "_exh"}, exhausted, 1'b0);
    check({tag, "_start"}, aes_start, 1'b0);
    check({tag, "_tried"}, tried, '0);
    check({tag, "_fidx"}, found_idx, '0);
    check({tag, "_fkb"}, found_kb, '0);
    check({tag, "_kb"}, kb, '0);
  endtask

  initial begin
    logic [447:0] a5;
    int unsigned  p0, n;
    a5 = {56{8'hA5}};

    #1 rst = 1'b1;
    #2 check_all_zero("reset");
    tick(); tick();
    rst = 1'b0;
    tick();

    // Valid at 7 in range 5..9
    valid_en = 1'b1; valid_idx = 32'd7;
    p0 = pulses;
    launch(a5, 32'd5, 32'd9);
    check("t1_start_lat", aes_start, 1'b1);
    check("t1_kb", kb, {a5[447:32], 32'd5});
    wait_idle("t1_timeout");
    check("t1_pulses", pulses - p0, 3);
    check("t1_found", found, 1'b1);
    check("t1_fidx", found_idx, 32'd7);
    check("t1_fkb_lo", found_kb[31:0], 32'd7);
    check("t1_fkb_hi", found_kb[447:32], a5[447:32]);
    check("t1_tried", tried, 32'd3);
    check("t1_exh", exhausted, 1'b0);

    // No valid, range 0..3
    valid_en = 1'b0;
    p0 = pulses;
    launch(a5, 32'd0, 32'd3);
    wait_idle("t2_timeout");
    check("t2_pulses", pulses - p0, 4);
    check("t2_exh", exhausted, 1'b1);
    check("t2_found", found, 1'b0);
    check("t2_tried", tried, 32'd4);
    check("t2_gap", violations, 0);

    // Top of range, no wrap
    p0 = pulses;
    launch(a5, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle("t3_timeout");
    repeat (15) tick();
    check("t3_pulses", pulses - p0, 1);
    check("t3_exh", exhausted, 1'b1);
    check("t3_tried", tried, 32'd1);
    check("t3_busy", busy, 1'b0);

    // Empty range
    p0 = pulses;
    launch(a5, 32'd10, 32'd3);
    check("t4_exh", exhausted, 1'b1);
    check("t4_busy", busy, 1'b0);
    repeat (8) begin tick(); check("t4_busy_hold", busy, 1'b0); end
    check("t4_pulses", pulses - p0, 0);

    // Abort in second WAIT; that strobe carries aes_valid=1
    valid_en = 1'b1; valid_idx = 32'd1;
    p0 = pulses;
    launch(a5, 32'd0, 32'd9);
    n = 0;
    while (!((pulses - p0) == 2 && !aes_start) && n < 100) begin tick(); n++; end
    check("t5_reach_wait", (pulses - p0) == 2 && !aes_start, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_busy_drain", busy, 1'b1);
    wait_idle("t5_timeout");
    check("t5_found", found, 1'b0);
    check("t5_exh", exhausted, 1'b0);
    check("t5_tried", tried, 32'd1);
    repeat (20) tick();
    check("t5_pulses", pulses - p0, 2);

    // Stall in WAIT with a spurious strobe during the stall
    valid_idx = 32'd2;
    p0 = pulses;
    launch(a5, 32'd0, 32'd3);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin inj_done = 1'b1; inj_valid = 1'b1; end
      if (i == 5) begin inj_done = 1'b0; inj_valid = 1'b0; end
      tick();
    end
    check("t6_tried_hold", tried, 32'd0);
    check("t6_busy_hold", busy, 1'b1);
    check("t6_start_hold", aes_start, 1'b0);
    stall = 1'b0;
    wait_idle("t6_timeout");
    check("t6_found", found, 1'b1);
    check("t6_fidx", found_idx, 32'd2);
    check("t6_tried", tried, 32'd3);
    check("t6_pulses", pulses - p0, 3);
    check("t6_gap", violations, 0);

    // Asynchronous reset during GAP
    valid_en = 1'b0;
    launch(a5, 32'd0, 32'd9);
    n = 0;
    while (!(tried == 32'd1 && busy && !aes_start) && n < 100) begin tick(); n++; end
    check("t7_reach_gap", tried == 32'd1 && busy && !aes_start, 1'b1);
    #1 rst = 1'b1;
    #1 check_all_zero("t7_async");
    tick();
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
